// File: rtl/axi_burst_ram_slave.sv
// AXI3-style burst slave over an internal RAM; write and read channels run independently.
// Latency: B one cycle after last W beat; first R beat 2 edges after AR handshake, 1 idle cycle between beats.
// Backpressure: one outstanding burst per direction; R outputs hold while rvalid && !rready.
module axi_burst_ram_slave #(
  parameter int AXI_DW = 64,
  parameter int RAM_DW = 16,
  parameter int RAM_AW = 13,
  parameter int DEPTH  = 8192
) (
  input  logic                a_clk,
  input  logic                a_rst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [AXI_DW-1:0]   wdata,
  input  logic [AXI_DW/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [31:0]         araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [AXI_DW-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] DEPTH_W     = 32'(DEPTH);
  localparam int          NB          = RAM_DW / 8;

  // Reserved burst type, or WRAP with a non power-of-two beat count.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [3:0] len);
    return (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  // Illegal requests are executed as INCR (and flagged separately).
  function automatic logic [1:0] burst_eff(input logic [1:0] burst, input logic [3:0] len);
    return burst_bad(burst, len) ? BURST_INCR : burst;
  endfunction

  // Address counts in full width so a burst running past the RAM top stays
  // out of range instead of aliasing back onto word 0. WRAP only ever sees
  // len in {1,3,7,15}, so len itself is the wrap mask.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                            input logic [3:0] len);
    logic [31:0] mask;
    mask = {28'd0, len};
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + 32'd1) & mask);
      default:     next_addr = addr + 32'd1;
    endcase
  endfunction

  logic [RAM_DW-1:0] mem [DEPTH];

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t    w_state, w_state_nxt;
  logic [31:0] w_addr;
  logic [3:0]  w_len, w_cnt;
  logic [1:0]  w_burst;
  logic        w_err;
  logic        w_beat, w_last_beat, w_in_range;

  assign w_beat      = (w_state == W_DATA) && wvalid;
  assign w_last_beat = (w_cnt == w_len);
  assign w_in_range  = (w_addr < DEPTH_W);

  // Write FSM state register.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  // Write FSM next state and handshake outputs.
  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    bresp       = RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_last_beat) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write burst context: latch on AW, advance per beat, accumulate errors.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= BURST_INCR;
      w_err   <= 1'b0;
    end else if ((w_state == W_IDLE) && awvalid) begin
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_burst <= burst_eff(awburst, awlen);
      w_cnt   <= '0;
      w_err   <= burst_bad(awburst, awlen);
    end else if (w_beat) begin
      w_addr <= next_addr(w_addr, w_burst, w_len);
      w_cnt  <= w_cnt + 4'd1;
      if (!w_in_range || (wlast != w_last_beat)) w_err <= 1'b1;
    end
  end

  // RAM write port with byte-lane enables; out-of-range beats are dropped.
  always_ff @(posedge a_clk) begin
    if (w_beat && w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[w_addr[RAM_AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  r_state_t    r_state, r_state_nxt;
  logic [31:0] r_addr;
  logic [3:0]  r_len, r_cnt;
  logic [1:0]  r_burst;
  logic        r_err;
  logic        r_in_range, r_last_beat;

  assign r_in_range  = (r_addr < DEPTH_W);
  assign r_last_beat = (r_cnt == r_len);

  // Read FSM state register.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_nxt = R_FETCH;
      end
      R_FETCH: r_state_nxt = R_DATA;
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) r_state_nxt = r_last_beat ? R_IDLE : R_FETCH;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read burst context and registered R payload; payload only changes in
  // R_FETCH, so it is naturally stable while a beat waits for rready.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_INCR;
      r_err   <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_burst <= burst_eff(arburst, arlen);
            r_cnt   <= '0;
            r_err   <= burst_bad(arburst, arlen);
          end
        end
        R_FETCH: begin
          rdata <= r_in_range ? AXI_DW'(mem[r_addr[RAM_AW-1:0]]) : '0;
          rresp <= (r_err || !r_in_range) ? RESP_SLVERR : RESP_OKAY;
          rlast <= r_last_beat;
        end
        R_DATA: begin
          if (rready) begin
            rlast <= 1'b0;
            if (!r_last_beat) begin
              r_addr <= next_addr(r_addr, r_burst, r_len);
              r_cnt  <= r_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Size fields and upper data/strobe lanes carry no meaning for this RAM.
  logic unused_bits;
  assign unused_bits = ^{awsize, arsize, wdata, wstrb};

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Directed bench for axi_burst_ram_slave: table of bursts plus hand-written
// sequences for read stall, 16-beat wrap, same-address read/write and reset.
module tb_axi_burst_ram_slave;
  localparam int TMO = 50;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

  logic        a_clk, a_rst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic        arvalid, arready, rvalid, rready, rlast;

  int checks = 0;
  int errors = 0;

  logic [15:0] wbuf  [16];
  logic [15:0] ebuf  [16];
  logic [1:0]  erbuf [16];

  axi_burst_ram_slave dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_awready"}, awready, 1);
    chk({nm, "_arready"}, arready, 1);
    chk({nm, "_wready"},  wready,  0);
    chk({nm, "_bvalid"},  bvalid,  0);
    chk({nm, "_rvalid"},  rvalid,  0);
    chk({nm, "_rlast"},   rlast,   0);
    chk({nm, "_bresp"},   bresp,   0);
    chk({nm, "_rresp"},   rresp,   0);
    chk({nm, "_rdata"},   rdata,   0);
  endtask

  // Full write burst from wbuf[]; bad_last inverts wlast on every beat.
  task automatic do_write(input string nm, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [7:0] strb, input bit bad_last,
                          input logic [1:0] exp_resp);
    int t;
    @(negedge a_clk);
    awvalid = 1'b1; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd1;
    t = 0;
    while (!awready && t < TMO) begin @(negedge a_clk); t++; end
    @(negedge a_clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = 64'(wbuf[i]); wstrb = strb;
      wlast = ((i == int'(len)) != bad_last);
      t = 0;
      while (!wready && t < TMO) begin @(negedge a_clk); t++; end
      @(negedge a_clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < TMO) begin @(negedge a_clk); t++; end
    chk({nm, "_bvalid_seen"}, bvalid, 1);
    chk({nm, "_bresp"}, bresp, exp_resp);
    @(negedge a_clk);
    bready = 1'b0;
    chk({nm, "_awready_back"}, awready, 1);
  endtask

  // Full read burst checked against ebuf[]/erbuf[]; optional stall on one beat.
  task automatic do_read(input string nm, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int stall_beat, input int stall_n);
    int t;
    @(negedge a_clk);
    arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst; arsize = 3'd1; rready = 1'b1;
    t = 0;
    while (!arready && t < TMO) begin @(negedge a_clk); t++; end
    @(negedge a_clk);
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!rvalid && t < TMO) begin @(negedge a_clk); t++; end
      chk($sformatf("%s_gap%0d", nm, i), 64'(t), 64'd1);
      chk($sformatf("%s_rdata%0d", nm, i), rdata, 64'(ebuf[i]));
      chk($sformatf("%s_rresp%0d", nm, i), rresp, erbuf[i]);
      chk($sformatf("%s_rlast%0d", nm, i), rlast, (i == int'(len)));
      if (i == stall_beat) begin
        rready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          @(negedge a_clk);
          chk($sformatf("%s_hold_rvalid%0d", nm, k), rvalid, 1);
          chk($sformatf("%s_hold_rdata%0d", nm, k), rdata, 64'(ebuf[i]));
          chk($sformatf("%s_hold_rresp%0d", nm, k), rresp, erbuf[i]);
          chk($sformatf("%s_hold_rlast%0d", nm, k), rlast, (i == int'(len)));
        end
        rready = 1'b1;
      end
      @(negedge a_clk);
    end
    chk({nm, "_rvalid_end"}, rvalid, 0);
    chk({nm, "_arready_end"}, arready, 1);
    rready = 1'b0;
  endtask

  typedef struct packed {
    bit              wr;
    logic [31:0]     addr;
    logic [3:0]      len;
    logic [1:0]      burst;
    logic [7:0]      strb;
    bit              bad_last;
    logic [3:0][15:0] dat;   // write data, or expected read data
    logic [3:0][1:0]  resp;  // resp[0] = bresp for writes; per-beat rresp for reads
  } vec_t;

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input logic [7:0] strb, input bit bad,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic [1:0] r0, input logic [1:0] r1,
                              input logic [1:0] r2, input logic [1:0] r3);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.strb = strb; v.bad_last = bad;
    v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3;
    v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r2; v.resp[3] = r3;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int  t;
    bit  seen_b;
    vecs.push_back(mk(1, 32'h0A, 2, INCR,  8'h03, 0, 16'hABCD, 16'hFDDF, 16'hFAFA, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0A, 2, INCR,  8'h00, 0, 16'hABCD, 16'hFDDF, 16'hFAFA, 0, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 32'h0E, 3, WRAP,  8'h03, 0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0C, 1, FIXED, 8'h00, 0, 16'h0003, 16'h0003, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 32'h0C, 3, INCR,  8'h00, 0, 16'h0003, 16'h0004, 16'h0001, 16'h0002, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 32'h20, 0, INCR,  8'hFF, 0, 16'hFFFF, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 32'h20, 0, INCR,  8'h01, 0, 16'h1234, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h20, 0, INCR,  8'h00, 0, 16'hFF34, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 32'd8191, 1, INCR, 8'h03, 0, 16'h5555, 16'h6666, 0, 0, 2'b10, 0, 0, 0));
    vecs.push_back(mk(0, 32'd8191, 1, INCR, 8'h00, 0, 16'h5555, 16'h0000, 0, 0, 2'b00, 2'b10, 0, 0));
    vecs.push_back(mk(1, 32'h30, 1, RSVD,  8'h03, 0, 16'h0007, 16'h0008, 0, 0, 2'b10, 0, 0, 0));
    vecs.push_back(mk(0, 32'h30, 1, INCR,  8'h00, 0, 16'h0007, 16'h0008, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 32'h30, 1, RSVD,  8'h00, 0, 16'h0007, 16'h0008, 0, 0, 2'b10, 2'b10, 0, 0));
    vecs.push_back(mk(1, 32'h40, 2, WRAP,  8'h03, 0, 16'h000A, 16'h000B, 16'h000C, 0, 2'b10, 0, 0, 0));
    vecs.push_back(mk(0, 32'h40, 2, INCR,  8'h00, 0, 16'h000A, 16'h000B, 16'h000C, 0, 2'b00, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 32'h41, 1, WRAP,  8'h00, 0, 16'h000B, 16'h000A, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 32'h50, 1, INCR,  8'h03, 1, 16'h0051, 16'h0052, 0, 0, 2'b10, 0, 0, 0));
    vecs.push_back(mk(0, 32'h50, 1, INCR,  8'h00, 0, 16'h0051, 16'h0052, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 32'h60, 2, FIXED, 8'h03, 0, 16'h0001, 16'h0002, 16'h0003, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h60, 0, INCR,  8'h00, 0, 16'h0003, 0, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h10000, 0, INCR, 8'h00, 0, 16'h0000, 0, 0, 0, 2'b10, 0, 0, 0));

    a_rst = 1'b1;
    awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(negedge a_clk);
    chk_reset_vals("rst0");
    a_rst = 1'b0;

    // Table-driven bursts.
    foreach (vecs[n]) begin
      for (int i = 0; i < 4; i++) begin
        wbuf[i]  = vecs[n].dat[i];
        ebuf[i]  = vecs[n].dat[i];
        erbuf[i] = vecs[n].resp[i];
      end
      if (vecs[n].wr)
        do_write($sformatf("v%0d", n), vecs[n].addr, vecs[n].len, vecs[n].burst,
                 vecs[n].strb, vecs[n].bad_last, vecs[n].resp[0]);
      else
        do_read($sformatf("v%0d", n), vecs[n].addr, vecs[n].len, vecs[n].burst, -1, 0);
    end

    // Read with rready low for 5 cycles on beat 2.
    ebuf[0] = 16'h0003; ebuf[1] = 16'h0004; ebuf[2] = 16'h0001; ebuf[3] = 16'h0002;
    for (int i = 0; i < 4; i++) erbuf[i] = 2'b00;
    do_read("stall", 32'h0C, 3, INCR, 1, 5);

    // 16-beat INCR write, read back as a 16-beat WRAP starting mid-block.
    for (int i = 0; i < 16; i++) wbuf[i] = 16'h0100 + 16'(i);
    do_write("w16", 32'h100, 15, INCR, 8'h03, 0, 2'b00);
    for (int i = 0; i < 16; i++) begin
      ebuf[i]  = 16'h0100 + 16'((5 + i) % 16);
      erbuf[i] = 2'b00;
    end
    do_read("r16", 32'h105, 15, WRAP, -1, 0);

    // Same-address write and read in the same cycle: read sees old data.
    wbuf[0] = 16'h1111;
    do_write("rbw_pre", 32'h80, 0, INCR, 8'h03, 0, 2'b00);
    @(negedge a_clk);
    awvalid = 1; awaddr = 32'h80; awlen = 0; awburst = INCR;
    wvalid = 1; wdata = 64'h2222; wstrb = 8'h03; wlast = 1;
    arvalid = 1; araddr = 32'h80; arlen = 0; arburst = INCR;
    chk("rbw_both_ready", {awready, arready}, 2'b11);
    @(negedge a_clk);
    awvalid = 0; arvalid = 0;
    @(negedge a_clk);
    wvalid = 0; wlast = 0;
    chk("rbw_rvalid", rvalid, 1);
    chk("rbw_old_data", rdata, 64'h1111);
    chk("rbw_bvalid", bvalid, 1);
    chk("rbw_bresp", bresp, 2'b00);
    rready = 1; bready = 1;
    @(negedge a_clk);
    rready = 0; bready = 0;
    chk("rbw_idle", {rvalid, bvalid}, 2'b00);
    ebuf[0] = 16'h2222; erbuf[0] = 2'b00;
    do_read("rbw_new", 32'h80, 0, INCR, -1, 0);

    // Reset during W_DATA after one of four beats.
    @(negedge a_clk);
    awvalid = 1; awaddr = 32'h70; awlen = 3; awburst = INCR;
    t = 0;
    while (!awready && t < TMO) begin @(negedge a_clk); t++; end
    @(negedge a_clk);
    awvalid = 0;
    wvalid = 1; wdata = 64'hAAAA; wstrb = 8'h03; wlast = 0;
    chk("mid_wready", wready, 1);
    @(negedge a_clk);
    wvalid = 0;
    chk("mid_wready2", wready, 1);
    a_rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    @(negedge a_clk);
    a_rst = 1'b0;
    bready = 1'b1;
    seen_b = 0;
    repeat (6) begin
      @(negedge a_clk);
      if (bvalid) seen_b = 1;
    end
    bready = 1'b0;
    chk("rst_no_bvalid", seen_b, 0);
    ebuf[0] = 16'hAAAA; erbuf[0] = 2'b00;
    do_read("rst_keep", 32'h70, 0, INCR, -1, 0);
    wbuf[0] = 16'hBBBB;
    do_write("rst_new_w", 32'h71, 0, INCR, 8'h03, 0, 2'b00);
    ebuf[0] = 16'hAAAA; ebuf[1] = 16'hBBBB; erbuf[0] = 2'b00; erbuf[1] = 2'b00;
    do_read("rst_new_r", 32'h70, 1, INCR, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
